// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential restoring divider: state encoding,
// the divide-by-zero quotient pattern and the iteration counter sizing.
package divider_seq_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Wide enough for any practical BUS_WIDTH; users slice the low bits.
    localparam int DIV_MAX_WIDTH = 64;
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    function automatic int div_count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/divider_seq_subtract.sv
// Plain unsigned subtractor; the divider's only arithmetic element.
// The MSB of the difference doubles as the borrow/sign flag.
module subtract
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference
);

    assign difference = minuend - subtrahend;

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring unsigned divider with a start/done handshake.
// One quotient bit per clock, using a single shared subtract stage.
//
// state    | meaning
// ---------+----------------------------------------------------------
// DIV_IDLE | waiting for i_start; results from last division held
// DIV_RUN  | one shift/subtract/restore iteration per clock
// DIV_DONE | results just loaded; o_done pulses for this one cycle
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [BUS_WIDTH-1:0] i_a,
    input  logic [BUS_WIDTH-1:0] i_b,
    output logic [BUS_WIDTH-1:0] o_quotient,
    output logic [BUS_WIDTH-1:0] o_remainder,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_div_by_zero
);

    localparam int CNT_W = div_count_width(BUS_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BUS_WIDTH - 1);

    logic [1:0]           state;
    logic [BUS_WIDTH-1:0] q_reg;
    logic [BUS_WIDTH-1:0] d_reg;
    // The partial remainder is always below the divisor after an iteration,
    // so its top bit is zero and only the low BUS_WIDTH bits are stored.
    logic [BUS_WIDTH-1:0] r_reg;
    logic [CNT_W-1:0]     iter_cnt;

    logic [BUS_WIDTH:0]   r_shift;
    logic [BUS_WIDTH:0]   diff;
    logic [BUS_WIDTH-1:0] r_next;
    logic [BUS_WIDTH-1:0] q_next;

    logic [BUS_WIDTH-1:0] quotient;
    logic [BUS_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    assign r_shift = {r_reg, q_reg[BUS_WIDTH-1]};

    subtract #(
        .WIDTH(BUS_WIDTH + 1)
    ) u_subtract (
        .minuend   (r_shift),
        .subtrahend({1'b0, d_reg}),
        .difference(diff)
    );

    // Borrow out of the subtract means the divisor did not fit: restore.
    always_comb begin
        r_next = diff[BUS_WIDTH-1:0];
        q_next = {q_reg[BUS_WIDTH-2:0], 1'b1};
        if (diff[BUS_WIDTH]) begin
            r_next = r_shift[BUS_WIDTH-1:0];
            q_next = {q_reg[BUS_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= DIV_IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            iter_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (i_start) begin
                        if (i_b == '0) begin
                            quotient    <= DIV_ZERO_QUOTIENT[BUS_WIDTH-1:0];
                            remainder   <= i_a;
                            div_by_zero <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            q_reg       <= i_a;
                            d_reg       <= i_b;
                            r_reg       <= '0;
                            iter_cnt    <= '0;
                            div_by_zero <= 1'b0;
                            state       <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    q_reg    <= q_next;
                    r_reg    <= r_next;
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    if (iter_cnt == LAST_ITER) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        state     <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign o_quotient    = quotient;
    assign o_remainder   = remainder;
    assign o_div_by_zero = div_by_zero;
    assign o_busy        = (state != DIV_IDLE);
    assign o_done        = (state == DIV_DONE);

endmodule

// File: tb/tb_divider_seq.sv
// Directed and randomised checks of divider_seq at BUS_WIDTH 8 and 16,
// against hand-computed values and a / % reference.
module tb_divider_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, busy8, done8, dbz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        start16, busy16, done16, dbz16;
    logic [15:0] a16, b16, q16, r16;

    int n_vec  = 0;
    int n_fail = 0;

    divider_seq #(.BUS_WIDTH(8)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_start(start8), .i_a(a8), .i_b(b8),
        .o_quotient(q8), .o_remainder(r8), .o_busy(busy8), .o_done(done8),
        .o_div_by_zero(dbz8)
    );

    divider_seq #(.BUS_WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(start16), .i_a(a16), .i_b(b16),
        .o_quotient(q16), .o_remainder(r16), .o_busy(busy16), .o_done(done16),
        .o_div_by_zero(dbz16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        if (w == 16) begin
            a16 = a; b16 = b; start16 = s;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = s;
        end
    endtask

    function automatic logic [15:0] obs_q(input int w);
        return (w == 16) ? q16 : {8'h00, q8};
    endfunction
    function automatic logic [15:0] obs_r(input int w);
        return (w == 16) ? r16 : {8'h00, r8};
    endfunction
    function automatic logic obs_busy(input int w);
        return (w == 16) ? busy16 : busy8;
    endfunction
    function automatic logic obs_done(input int w);
        return (w == 16) ? done16 : done8;
    endfunction
    function automatic logic obs_dbz(input int w);
        return (w == 16) ? dbz16 : dbz8;
    endfunction

    // One division: cycle n counts negedges after the accepting edge, so a
    // normal result shows o_done at n = w+1 and divide-by-zero at n = 1.
    // inject_at > 0 raises i_start (200/3) for one cycle at that n.
    task automatic do_div(input int w, input logic [15:0] a, input logic [15:0] b,
                          input int inject_at, input string tag);
        logic [15:0] mask, eq, er, q_at, r_at;
        logic        dbz_at;
        int          elat, lat, busy_cnt, done_cnt;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (b == 16'd0) begin
            eq = mask; er = a; elat = 1;
        end else begin
            eq = a / b; er = a % b; elat = w + 1;
        end
        lat = 0; busy_cnt = 0; done_cnt = 0;
        q_at = '0; r_at = '0; dbz_at = 1'b0;
        @(negedge clk);
        drive(w, a, b, 1'b1);
        @(posedge clk);
        #1 drive(w, ~a, ~b, 1'b0);
        for (int n = 1; n <= w + 6; n++) begin
            @(negedge clk);
            if (n == inject_at)
                drive(w, 16'd200, 16'd3, 1'b1);
            else if (n == inject_at + 1)
                drive(w, 16'd200, 16'd3, 1'b0);
            if (obs_busy(w)) busy_cnt++;
            if (obs_done(w)) begin
                done_cnt++;
                if (lat == 0) begin
                    lat = n; q_at = obs_q(w); r_at = obs_r(w); dbz_at = obs_dbz(w);
                end
            end
        end
        check({tag, " latency"},   lat,      elat);
        check({tag, " done_cnt"},  done_cnt, 1);
        check({tag, " busy_cnt"},  busy_cnt, elat);
        check({tag, " quotient"},  q_at,     eq);
        check({tag, " remainder"}, r_at,     er);
        check({tag, " dbz"},       dbz_at,   (b == 16'd0));
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] mask;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        case ($urandom_range(0, 9))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return mask;
            default: return 16'($urandom) & mask;
        endcase
    endfunction

    initial begin
        int dcnt;
        rst = 1'b1;
        drive(8, 16'd0, 16'd0, 1'b0);
        drive(16, 16'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst q8",    q8,    0);
        check("rst r8",    r8,    0);
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst dbz8",  dbz8,  0);
        check("rst q16",   q16,   0);
        check("rst busy16", busy16, 0);
        rst = 1'b0;

        do_div(8, 16'd100, 16'd7,   0, "100/7");
        do_div(8, 16'd255, 16'd1,   0, "255/1");
        do_div(8, 16'd255, 16'd255, 0, "255/255");
        do_div(8, 16'd5,   16'd9,   0, "5/9");
        do_div(8, 16'd42,  16'd0,   0, "42/0");
        repeat (3) @(negedge clk);
        check("hold dbz",  dbz8, 1);
        check("hold q",    q8,   8'hFF);
        check("hold r",    r8,   8'd42);
        check("hold busy", busy8, 0);

        // Reset in the fourth RUN cycle discards the division.
        @(negedge clk);
        drive(8, 16'd100, 16'd7, 1'b1);
        @(posedge clk);
        #1 drive(8, 16'd0, 16'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst q",    q8,    0);
        check("midrst r",    r8,    0);
        check("midrst busy", busy8, 0);
        check("midrst done", done8, 0);
        check("midrst dbz",  dbz8,  0);
        dcnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        check("midrst no done", dcnt, 0);
        do_div(8, 16'd60, 16'd8, 0, "60/8");

        do_div(8, 16'd100, 16'd7, 3, "ignored start");
        do_div(8, 16'd255, 16'd0, 0, "255/0");
        do_div(8, 16'd0,   16'd1, 0, "0/1");

        do_div(16, 16'd65535, 16'd255, 0, "w16 65535/255");
        do_div(16, 16'd50000, 16'd0,   0, "w16 50000/0");
        do_div(16, 16'd1000,  16'd3,   0, "w16 1000/3");
        do_div(16, 16'd7,     16'd65535, 0, "w16 7/65535");

        for (int i = 0; i < 500; i++) begin
            logic [15:0] ra, rb;
            ra = pick(8);
            rb = pick(8);
            do_div(8, ra, rb, 0, $sformatf("rand8 %0d/%0d", ra, rb));
        end
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ra, rb;
            ra = pick(16);
            rb = pick(16);
            do_div(16, ra, rb, 0, $sformatf("rand16 %0d/%0d", ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
